// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the six-instruction processor control unit.
//   - opcode values (OP_LOAD..OP_JMPZ, OP_HALT)
//   - control FSM state encoding
//   - register-file write-data select (rf_s) and ALU op (alu_s) encodings
// Optional build macro: CU_HALT_EN adds the StHalt state.
package cu_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_LDC   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMPZ  = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    StInit,
    StFetch,
    StDecode,
    StLoad,
    StStore,
    StAdd,
    StLdc,
    StSub,
    StJmpz,
    StJump
`ifdef CU_HALT_EN
    ,
    StHalt
`endif
  } state_e;

  // Register-file write-data select
  localparam logic [1:0] RF_S_ALU   = 2'b00;
  localparam logic [1:0] RF_S_MEM   = 2'b01;
  localparam logic [1:0] RF_S_CONST = 2'b10;

  // ALU operation select
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/cu_pc.sv
// cu_pc: program-counter register for the control unit.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear to 0 (highest priority)
//   inc  - pc <= pc + 1, wrapping modulo 2^PC_W
//   ld   - relative load: pc <= pc + sext(off) - 1, modulo 2^PC_W
//   off  - signed OFF_W-bit relative offset
//   pc   - current program counter
module cu_pc #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             ld,
  input  logic [OFF_W-1:0] off,
  output logic [PC_W-1:0]  pc
);

  localparam int unsigned ExtW = (PC_W > OFF_W) ? PC_W : OFF_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [ExtW-1:0] off_ext;
  logic [ExtW-1:0] rel_sum;

  // pc has already been incremented past the jump instruction, hence the -1
  // so the target is relative to the instruction's own address.
  assign off_ext = ExtW'($signed(off));
  assign rel_sum = ExtW'(pc_q) + off_ext - ExtW'(1);

  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (ld) begin
      pc_d = rel_sum[PC_W-1:0];
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for the six-instruction processor.
// Owns the program counter, drives instruction fetch and decodes the
// instruction register into data-memory, register-file and ALU strobes.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   ir                   - instruction register contents
//   ir_ld, i_rd, i_addr  - instruction fetch (i_addr = pc)
//   d_addr, d_rd, d_wr   - data memory
//   rf_*                 - register-file write/read controls, rf_rp_zero status in
//   alu_s                - ALU operation
//   halted               - only present when CU_HALT_EN is defined
// Optional build macro: CU_HALT_EN (op 0xF halts until reset; otherwise a NOP).
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned D_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     ir,
  output logic            ir_ld,
  output logic            i_rd,
  output logic [PC_W-1:0] i_addr,
  output logic [D_W-1:0]  d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic [D_W-1:0]  rf_w_data,
  output logic [1:0]      rf_s,
  output logic [3:0]      rf_w_addr,
  output logic            rf_w_wr,
  output logic [3:0]      rf_rp_addr,
  output logic [3:0]      rf_rq_addr,
  output logic            rf_rp_rd,
  output logic            rf_rq_rd,
  input  logic            rf_rp_zero,
  output logic [1:0]      alu_s
`ifdef CU_HALT_EN
  ,
  output logic            halted
`endif
);

  state_e state_q, state_d;

  logic [PC_W-1:0] pc;
  logic [3:0]      op, ra, rb, rc;
  logic [7:0]      imm;

  assign op  = ir[15:12];
  assign ra  = ir[11:8];
  assign rb  = ir[7:4];
  assign rc  = ir[3:0];
  assign imm = ir[7:0];

  cu_pc #(
    .PC_W  (PC_W),
    .OFF_W (8)
  ) u_pc (
    .clk (clk),
    .clr (reset || (state_q == StInit)),
    .inc (!reset && (state_q == StFetch)),
    .ld  (!reset && (state_q == StJump)),
    .off (imm),
    .pc  (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs; everything stays 0 while reset is high so no write can
  // slip out in the reset cycle.
  always_comb begin
    state_d    = state_q;
    ir_ld      = 1'b0;
    i_rd       = 1'b0;
    i_addr     = '0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_s       = RF_S_ALU;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_rp_addr = '0;
    rf_rq_addr = '0;
    rf_rp_rd   = 1'b0;
    rf_rq_rd   = 1'b0;
    alu_s      = ALU_PASS;
`ifdef CU_HALT_EN
    halted     = 1'b0;
`endif

    if (!reset) begin
      i_addr = pc;
      unique case (state_q)
        StInit: begin
          state_d = StFetch;
        end
        StFetch: begin
          i_rd    = 1'b1;
          ir_ld   = 1'b1;
          state_d = StDecode;
        end
        StDecode: begin
          case (op)
            OP_LOAD:  state_d = StLoad;
            OP_STORE: state_d = StStore;
            OP_ADD:   state_d = StAdd;
            OP_LDC:   state_d = StLdc;
            OP_SUB:   state_d = StSub;
            OP_JMPZ:  state_d = StJmpz;
`ifdef CU_HALT_EN
            OP_HALT:  state_d = StHalt;
`endif
            default:  state_d = StFetch;
          endcase
        end
        StLoad: begin
          d_addr    = D_W'(imm);
          d_rd      = 1'b1;
          rf_s      = RF_S_MEM;
          rf_w_addr = ra;
          rf_w_wr   = 1'b1;
          state_d   = StFetch;
        end
        StStore: begin
          d_addr     = D_W'(imm);
          d_wr       = 1'b1;
          rf_rp_addr = ra;
          rf_rp_rd   = 1'b1;
          state_d    = StFetch;
        end
        StAdd, StSub: begin
          rf_rp_addr = rb;
          rf_rq_addr = rc;
          rf_rp_rd   = 1'b1;
          rf_rq_rd   = 1'b1;
          alu_s      = (state_q == StAdd) ? ALU_ADD : ALU_SUB;
          rf_s       = RF_S_ALU;
          rf_w_addr  = ra;
          rf_w_wr    = 1'b1;
          state_d    = StFetch;
        end
        StLdc: begin
          rf_s      = RF_S_CONST;
          rf_w_data = D_W'(imm);
          rf_w_addr = ra;
          rf_w_wr   = 1'b1;
          state_d   = StFetch;
        end
        StJmpz: begin
          rf_rp_addr = ra;
          rf_rp_rd   = 1'b1;
          state_d    = rf_rp_zero ? StJump : StFetch;
        end
        StJump: begin
          state_d = StFetch;
        end
`ifdef CU_HALT_EN
        StHalt: begin
          halted  = 1'b1;
          state_d = StHalt;
        end
`endif
        default: begin
          state_d = StInit;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit.
// An instruction-level model predicts every output cycle of each instruction
// and queues it; a monitor pops and compares one record per clock.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        ir_ld, i_rd, d_rd, d_wr, rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic [7:0]  i_addr, d_addr, rf_w_data;
  logic [1:0]  rf_s, alu_s;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic        rp_zero;
`ifdef CU_HALT_EN
  logic        halted;
`endif

  control_unit #(
    .PC_W (8),
    .D_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ir         (ir),
    .ir_ld      (ir_ld),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .d_addr     (d_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .rf_w_data  (rf_w_data),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_wr    (rf_w_wr),
    .rf_rp_addr (rf_rp_addr),
    .rf_rq_addr (rf_rq_addr),
    .rf_rp_rd   (rf_rp_rd),
    .rf_rq_rd   (rf_rq_rd),
    .rf_rp_zero (rp_zero),
    .alu_s      (alu_s)
`ifdef CU_HALT_EN
    ,
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_ld;
    logic       i_rd;
    logic [7:0] i_addr;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [7:0] rf_w_data;
    logic [1:0] rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_wr;
    logic [3:0] rf_rp_addr;
    logic [3:0] rf_rq_addr;
    logic       rf_rp_rd;
    logic       rf_rq_rd;
    logic [1:0] alu_s;
    logic       halted;
    logic       full;   // compare every field, including don't-care addresses
  } cyc_t;

  cyc_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;
  int    mpc;           // model program counter

  // Fields whose strobe is off are don't-care outside reset/INIT.
  function automatic cyc_t apply_mask(cyc_t v, cyc_t e);
    cyc_t r = v;
    r.full = e.full;
    if (!e.full) begin
      if (!(e.d_rd || e.d_wr)) r.d_addr = '0;
      if (!(e.rf_w_wr && e.rf_s == 2'b10)) r.rf_w_data = '0;
      if (!(e.rf_w_wr && e.rf_s == 2'b00)) r.alu_s = '0;
      if (!e.rf_w_wr) begin
        r.rf_w_addr = '0;
        r.rf_s      = '0;
      end
      if (!e.rf_rp_rd) r.rf_rp_addr = '0;
      if (!e.rf_rq_rd) r.rf_rq_addr = '0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc_t  a, e, am, em;
      string nm;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: DUT cycle with no expected record (check %0d)", checks);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '0;
        a.ir_ld      = ir_ld;
        a.i_rd       = i_rd;
        a.i_addr     = i_addr;
        a.d_addr     = d_addr;
        a.d_rd       = d_rd;
        a.d_wr       = d_wr;
        a.rf_w_data  = rf_w_data;
        a.rf_s       = rf_s;
        a.rf_w_addr  = rf_w_addr;
        a.rf_w_wr    = rf_w_wr;
        a.rf_rp_addr = rf_rp_addr;
        a.rf_rq_addr = rf_rq_addr;
        a.rf_rp_rd   = rf_rp_rd;
        a.rf_rq_rd   = rf_rq_rd;
        a.alu_s      = alu_s;
`ifdef CU_HALT_EN
        a.halted     = halted;
`endif
        am = apply_mask(a, e);
        em = apply_mask(e, e);
        if (am !== em) begin
          errors++;
          $display("FAIL %s (check %0d, t=%0t): got %h expected %h", nm, checks, $time, am, em);
        end
      end
    end
  end

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic push(cyc_t c, string nm);
    exp_q.push_back(c);
    name_q.push_back(nm);
  endtask

  function automatic cyc_t blank(int pc);
    cyc_t c = '0;
    c.i_addr = 8'(pc);
    return c;
  endfunction

  task automatic do_reset(int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      cycle_start();
      reset = 1'b1;
      c = '0;
      c.full = 1'b1;
      push(c, "reset");
    end
    cycle_start();
    reset = 1'b0;
    mpc = 0;
    c = '0;
    c.full = 1'b1;
    push(c, "init");
  endtask

  task automatic fetch_decode(logic [15:0] iv, logic z);
    cyc_t c;
    cycle_start();
    ir      = iv;
    rp_zero = z;
    c = blank(mpc);
    c.ir_ld = 1'b1;
    c.i_rd  = 1'b1;
    push(c, "fetch");
    cycle_start();
    push(blank((mpc + 1) % 256), "decode");
  endtask

  task automatic exec_rest(logic [15:0] iv, logic z);
    cyc_t c;
    int   pcn = (mpc + 1) % 256;
    c = blank(pcn);
    case (iv[15:12])
      4'h0: begin
        cycle_start();
        c.d_rd = 1'b1; c.d_addr = iv[7:0];
        c.rf_s = 2'b01; c.rf_w_addr = iv[11:8]; c.rf_w_wr = 1'b1;
        push(c, "load");
        mpc = pcn;
      end
      4'h1: begin
        cycle_start();
        c.d_wr = 1'b1; c.d_addr = iv[7:0];
        c.rf_rp_addr = iv[11:8]; c.rf_rp_rd = 1'b1;
        push(c, "store");
        mpc = pcn;
      end
      4'h2, 4'h4: begin
        cycle_start();
        c.rf_rp_addr = iv[7:4]; c.rf_rq_addr = iv[3:0];
        c.rf_rp_rd = 1'b1; c.rf_rq_rd = 1'b1;
        c.alu_s = (iv[15:12] == 4'h2) ? 2'b01 : 2'b10;
        c.rf_s = 2'b00; c.rf_w_addr = iv[11:8]; c.rf_w_wr = 1'b1;
        push(c, (iv[15:12] == 4'h2) ? "add" : "sub");
        mpc = pcn;
      end
      4'h3: begin
        cycle_start();
        c.rf_s = 2'b10; c.rf_w_data = iv[7:0];
        c.rf_w_addr = iv[11:8]; c.rf_w_wr = 1'b1;
        push(c, "ldc");
        mpc = pcn;
      end
      4'h5: begin
        cycle_start();
        c.rf_rp_addr = iv[11:8]; c.rf_rp_rd = 1'b1;
        push(c, "jmpz");
        if (z) begin
          cycle_start();
          push(blank(pcn), "jump");
          // target is relative to the JMPZ's own address
          mpc = (mpc + 256 + int'($signed(iv[7:0]))) % 256;
        end else begin
          mpc = pcn;
        end
      end
`ifdef CU_HALT_EN
      4'hF: begin
        mpc = pcn;
        for (int i = 0; i < 10; i++) begin
          cycle_start();
          c = blank(pcn);
          c.halted = 1'b1;
          push(c, "halt");
        end
        do_reset(1);
      end
`endif
      default: mpc = pcn;
    endcase
  endtask

  task automatic exec_instr(logic [15:0] iv, logic z);
    fetch_decode(iv, z);
    exec_rest(iv, z);
  endtask

  task automatic advance_to(int target);
    logic [31:0] r;
    while (mpc != target) begin
      r = $urandom();
      exec_instr({4'(6 + (r[15:12] % 9)), r[11:0]}, r[16]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    reset   = 1'b1;
    ir      = '0;
    rp_zero = 1'b0;

    do_reset(2);
    exec_instr(16'h3A2C, 1'b0);          // MOVI R10,#0x2C at pc 0
    exec_instr(16'h2123, 1'b0);          // ADD
    exec_instr(16'h4123, 1'b0);          // SUB
    advance_to(8'h10);
    exec_instr(16'h50FD, 1'b1);          // taken -> 0x0D
    advance_to(8'h10);
    exec_instr(16'h50FD, 1'b0);          // not taken -> 0x11
    advance_to(8'h10);
    exec_instr(16'h5300, 1'b1);          // offset 0: loops on itself
    exec_instr(16'h5300, 1'b0);
    advance_to(8'hFF);
    exec_instr(16'h7000, 1'b0);          // NOP at 0xFF wraps to 0
    exec_instr(16'h0642, 1'b0);          // LOAD
    fetch_decode(16'h1305, 1'b0);        // STORE abandoned by reset
    do_reset(1);
`ifdef CU_HALT_EN
    exec_instr(16'hF000, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      r  = $urandom();
      op = r[15:12];
      if (r[24:20] == 5'd0) begin
        fetch_decode({op, r[11:0]}, r[16]);
        do_reset(1);
      end else begin
        exec_instr({op, r[11:0]}, r[16]);
      end
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the six-instruction processor. It owns the program counter and drives instruction fetch. It decodes the 16-bit word held in the instruction register and generates every datapath strobe: data memory, register file and ALU. It sits directly downstream of the instruction register, consuming its output and driving its load enable.

## Interface
Parameters:
- PC_W, 8, program-counter / instruction-address width
- D_W, 8, data-memory address and constant width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ir  in  16  current instruction from instruction register
- ir_ld  out  1  instruction-register load enable
- i_rd  out  1  instruction-memory read
- i_addr  out  PC_W  instruction address (= pc)
- d_addr  out  D_W  data-memory address (ir[7:0])
- d_rd / d_wr  out  1 each  data-memory read / write
- rf_w_data  out  D_W  constant for MOVI (ir[7:0]); datapath zero-extends it
- rf_s  out  2  write-data select: 00 ALU, 01 memory, 10 constant
- rf_w_addr  out  4  register-file write address
- rf_w_wr  out  1  register-file write enable
- rf_rp_addr, rf_rq_addr  out  4 each  read-port addresses
- rf_rp_rd, rf_rq_rd  out  1 each  read enables
- rf_rp_zero  in  1  port-p read value equals zero
- alu_s  out  2  ALU op: 00 pass, 01 add, 10 subtract
- halted  out  1  present only with CU_HALT_EN

## Operation
- Instruction fields:
  - op = ir[15:12]
  - ra = ir[11:8], rb = ir[7:4], rc = ir[3:0]
  - d / C / offset = ir[7:0]
- States: INIT, FETCH, DECODE, LOAD, STORE, ADD, LDC, SUB, JMPZ, JUMP, plus HALT with the macro.
- INIT: all outputs 0; pc <= 0; next state FETCH.
- FETCH: i_rd=1, ir_ld=1; pc <= pc+1 (wraps 255->0); next DECODE.
- DECODE: no strobes. Transitions by op:
  - 0 -> LOAD
  - 1 -> STORE
  - 2 -> ADD
  - 3 -> LDC
  - 4 -> SUB
  - 5 -> JMPZ
  - any other op -> FETCH (NOP)
- LOAD (RF[ra]=D[d]): d_rd=1, rf_s=01, rf_w_addr=ra, rf_w_wr=1.
- STORE (D[d]=RF[ra]): rf_rp_addr=ra, rf_rp_rd=1, d_wr=1.
- ADD / SUB (RF[ra]=RF[rb]±RF[rc]):
  - rf_rp_addr=rb, rf_rq_addr=rc, both read enables 1
  - alu_s=01 for ADD, 10 for SUB
  - rf_s=00, rf_w_addr=ra, rf_w_wr=1
- LDC (RF[ra]=C): rf_s=10, rf_w_data=C, rf_w_addr=ra, rf_w_wr=1.
- JMPZ: rf_rp_addr=ra, rf_rp_rd=1. Next state is JUMP if rf_rp_zero, else FETCH.
- JUMP: pc <= pc + sext(offset) − 1, modulo 2^PC_W. The target is relative to the JMPZ instruction's own address. Next FETCH.
- All other execute states return to FETCH.
- Outputs are Moore (decoded from state and ir). Address fields are don't-care when their strobe is 0.

## Timing
- Reset value of every output: 0. pc=0, state=INIT.
- Every strobe is gated by !reset, so no memory or register write occurs in the reset cycle. Reset mid-instruction abandons that instruction.
- Execute cycles are one cycle each:
  - LOAD, STORE, ADD, SUB, LDC: 3 cycles (FETCH, DECODE, exec)
  - JMPZ not taken: 3 cycles
  - JMPZ taken: 4 cycles
  - NOP: 2 cycles
- After reset deasserts: one INIT cycle, then the first FETCH at pc=0.
- ir is sampled only in DECODE and execute states. It is stable then because ir_ld is asserted only in FETCH.
- Offset 0x00 with the zero condition true jumps to pc−1, the JMPZ itself, giving a tight loop.

## Configuration
- CU_HALT_EN defined:
  - op 0xF in DECODE -> HALT
  - HALT: all strobes 0, halted=1, pc frozen, stays there until reset
- Undefined: op 0xF is a NOP and the halted port is absent.

## Structure
- Shared package cu_pkg holds:
  - opcode localparams OP_LOAD..OP_JMPZ, OP_HALT
  - state encoding
  - rf_s and alu_s encodings
- Sub-module cu_pc: PC_W register with clr / inc / relative-load inputs and wrap-around adder.

## Test plan
- Reset held 2 cycles, then released -> all outputs 0 during reset; INIT one cycle; FETCH with i_addr=0, ir_ld=1; pc=1 in DECODE.
- ir=0x3A2C (MOVI R10,#0x2C) -> in LDC: rf_w_wr=1, rf_w_addr=0xA, rf_s=10, rf_w_data=0x2C; back in FETCH 3 cycles after the prior FETCH.
- ir=0x2123 then 0x4123 -> ADD then SUB: rf_rp_addr=2, rf_rq_addr=3, rf_w_addr=1, alu_s=01 then 10.
- JMPZ: pc of the JMPZ = 0x10, ir=0x50FD, rf_rp_zero=1 -> JUMP state; next FETCH i_addr=0x0D. With rf_rp_zero=0 -> next FETCH i_addr=0x11.
- pc=0xFF fetch, ir=0x7000 (NOP) -> next FETCH i_addr=0x00 two cycles later; no strobes in DECODE.
- Reset asserted during STORE (ir=0x1305) -> d_wr=0 that cycle; next cycle is INIT. With CU_HALT_EN: ir=0xF000 -> halted=1 and persists for 10 cycles until reset.
